laser_array_obstacle: RTL and testbench

LASER_ARRAY_OBSTACLE -- requirements
Module: laser_array_obstacle

---
 rtl/laser_array_obstacle.sv | 177 +++++++++++++++++
 tb/tb_laser_array_obstacle.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_array_obstacle.sv
// Laser-array obstacle overlay: fires a sequence of growing laser bars across the
// frame and marks the pixels they cover, with registered pixel outputs.
module laser_array_obstacle #(
  parameter logic [2:0]  SELECT_CODE    = 3'b010,
  parameter int          LASER_COUNT    = 3,
  parameter int          ORIENTATION    = 0,
  parameter int          SEQ_MODE       = 0,
  parameter int          FIRST_POS      = 367,
  parameter int          PITCH          = 100,
  parameter int          SPAN_LO        = 361,
  parameter int          SPAN_HI        = 661,
  parameter int          MAX_HALF_WIDTH = 40,
  parameter int          SPAWN_DELAY    = 32000000,
  parameter int          GROW_DELAY     = 3200000,
  parameter int          HOLD_DELAY     = 32000000,
  parameter int          SHOTS          = 16,
  parameter logic [11:0] COLOR          = 12'hfff
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] hcount_in,
  input  logic [11:0] vcount_in,
  input  logic [11:0] rgb_in,
  input  logic        play_selected,
  input  logic [2:0]  selected,
  input  logic        done_in,
  output logic [11:0] rgb_out,
  output logic [11:0] obstacle_x,
  output logic [11:0] obstacle_y,
  output logic        done
);

  localparam logic [24:0] SPAWN_LAST = 25'(SPAWN_DELAY - 1);
  localparam logic [24:0] GROW_LAST  = 25'(GROW_DELAY - 1);
  localparam logic [24:0] HOLD_LAST  = 25'(HOLD_DELAY - 1);
  localparam logic [6:0]  HW_MAX     = 7'(MAX_HALF_WIDTH);
  localparam logic [5:0]  SHOT_END   = 6'(SHOTS);
  localparam logic [2:0]  IDX_LAST   = 3'(LASER_COUNT - 1);

  typedef enum logic [1:0] {IDLE, SPAWN, GROW, HOLD} state_t;

  state_t      state, state_n;
  logic [24:0] cnt, cnt_n;
  logic [6:0]  hw, hw_n;
  logic [5:0]  shots, shots_n;
  logic [2:0]  idx, idx_n;
  logic        dir_up, dir_up_n;
  logic        done_n;
  logic [11:0] rgb_n, x_n, y_n;

  logic [11:0] centre, short_c, long_c;
  logic        in_laser, hit;

  assign centre  = 12'(FIRST_POS) + 12'(PITCH) * 12'(idx);
  assign short_c = (ORIENTATION == 0) ? vcount_in : hcount_in;
  assign long_c  = (ORIENTATION == 0) ? hcount_in : vcount_in;

  // Short-axis extent is asymmetric: a zero half-width still draws two pixels.
  assign in_laser = (long_c >= 12'(SPAN_LO)) && (long_c <= 12'(SPAN_HI)) &&
                    (short_c >= centre - 12'(hw)) &&
                    (short_c <= centre + 12'd1 + 12'(hw));
  assign hit = (state != IDLE) && in_laser;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    hw_n     = hw;
    shots_n  = shots;
    idx_n    = idx;
    dir_up_n = dir_up;
    done_n   = 1'b0;

    case (state)
      IDLE: begin
        if (done_in && play_selected && (selected == SELECT_CODE)) begin
          state_n  = SPAWN;
          cnt_n    = '0;
          hw_n     = '0;
          shots_n  = '0;
          idx_n    = '0;
          dir_up_n = 1'b1;
        end
      end
      SPAWN: begin
        if (cnt == SPAWN_LAST) begin
          state_n = GROW;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 25'd1;
        end
      end
      GROW: begin
        if (cnt == GROW_LAST) begin
          cnt_n = '0;
          hw_n  = hw + 7'd1;
          if (hw + 7'd1 == HW_MAX) state_n = HOLD;
        end else begin
          cnt_n = cnt + 25'd1;
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          cnt_n   = '0;
          shots_n = shots + 6'd1;
          if (shots + 6'd1 == SHOT_END) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = SPAWN;
            hw_n    = '0;
            if (SEQ_MODE == 0) begin
              idx_n = (idx == IDX_LAST) ? '0 : idx + 3'd1;
            end else if (LASER_COUNT == 1) begin
              idx_n = '0;
            end else if (dir_up) begin
              // Turn at the ends without firing the end laser twice.
              if (idx == IDX_LAST) begin
                idx_n    = idx - 3'd1;
                dir_up_n = 1'b0;
              end else begin
                idx_n = idx + 3'd1;
              end
            end else begin
              if (idx == '0) begin
                idx_n    = 3'd1;
                dir_up_n = 1'b1;
              end else begin
                idx_n = idx - 3'd1;
              end
            end
          end
        end else begin
          cnt_n = cnt + 25'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    if ((state != IDLE) && !play_selected) begin
      state_n = IDLE;
      cnt_n   = '0;
      hw_n    = '0;
      done_n  = 1'b0;
    end

    rgb_n = hit ? COLOR : rgb_in;
    x_n   = hit ? hcount_in : '0;
    y_n   = hit ? vcount_in : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      hw         <= '0;
      shots      <= '0;
      idx        <= '0;
      dir_up     <= 1'b1;
      done       <= 1'b0;
      rgb_out    <= '0;
      obstacle_x <= '0;
      obstacle_y <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      hw         <= hw_n;
      shots      <= shots_n;
      idx        <= idx_n;
      dir_up     <= dir_up_n;
      done       <= done_n;
      rgb_out    <= rgb_n;
      obstacle_x <= x_n;
      obstacle_y <= y_n;
    end
  end

endmodule

// File: tb/tb_laser_array_obstacle.sv
// Directed bench for laser_array_obstacle: geometry table on long-spawn instances,
// timeline sequences on short-delay ascending and ping-pong instances.
module tb_laser_array_obstacle;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // shared stimulus for the two short-delay instances
  logic [11:0] hc, vc, rgb;
  logic        play, dinp;
  logic [2:0]  sel;
  logic [11:0] a_rgb, a_x, a_y, p_rgb, p_x, p_y;
  logic        a_done, p_done;

  // stimulus for the long-spawn geometry instances
  logic [11:0] g_h, g_v, g_rgb;
  logic        g_play, g_din;
  logic [2:0]  g_sel;
  logic [11:0] gh_rgb, gh_x, gh_y, gv_rgb, gv_x, gv_y;
  logic        gh_done, gv_done;

  int checks = 0;
  int failures = 0;

  laser_array_obstacle #(
    .SELECT_CODE(3'b010), .LASER_COUNT(3), .ORIENTATION(0), .SEQ_MODE(0),
    .FIRST_POS(367), .PITCH(100), .SPAN_LO(361), .SPAN_HI(661),
    .MAX_HALF_WIDTH(2), .SPAWN_DELAY(4), .GROW_DELAY(2), .HOLD_DELAY(3),
    .SHOTS(4), .COLOR(12'hfff)
  ) u_asc (
    .clk(clk), .rst(rst), .hcount_in(hc), .vcount_in(vc), .rgb_in(rgb),
    .play_selected(play), .selected(sel), .done_in(dinp),
    .rgb_out(a_rgb), .obstacle_x(a_x), .obstacle_y(a_y), .done(a_done)
  );

  laser_array_obstacle #(
    .SELECT_CODE(3'b010), .LASER_COUNT(3), .ORIENTATION(0), .SEQ_MODE(1),
    .FIRST_POS(367), .PITCH(100), .SPAN_LO(361), .SPAN_HI(661),
    .MAX_HALF_WIDTH(2), .SPAWN_DELAY(4), .GROW_DELAY(2), .HOLD_DELAY(3),
    .SHOTS(4), .COLOR(12'hfff)
  ) u_pp (
    .clk(clk), .rst(rst), .hcount_in(hc), .vcount_in(vc), .rgb_in(rgb),
    .play_selected(play), .selected(sel), .done_in(dinp),
    .rgb_out(p_rgb), .obstacle_x(p_x), .obstacle_y(p_y), .done(p_done)
  );

  laser_array_obstacle #(
    .SELECT_CODE(3'b010), .LASER_COUNT(3), .ORIENTATION(0), .SEQ_MODE(0),
    .FIRST_POS(367), .PITCH(100), .SPAN_LO(361), .SPAN_HI(661),
    .MAX_HALF_WIDTH(2), .SPAWN_DELAY(1000), .GROW_DELAY(2), .HOLD_DELAY(3),
    .SHOTS(4), .COLOR(12'hfff)
  ) u_gh (
    .clk(clk), .rst(rst), .hcount_in(g_h), .vcount_in(g_v), .rgb_in(g_rgb),
    .play_selected(g_play), .selected(g_sel), .done_in(g_din),
    .rgb_out(gh_rgb), .obstacle_x(gh_x), .obstacle_y(gh_y), .done(gh_done)
  );

  laser_array_obstacle #(
    .SELECT_CODE(3'b010), .LASER_COUNT(3), .ORIENTATION(1), .SEQ_MODE(0),
    .FIRST_POS(367), .PITCH(100), .SPAN_LO(361), .SPAN_HI(661),
    .MAX_HALF_WIDTH(2), .SPAWN_DELAY(1000), .GROW_DELAY(2), .HOLD_DELAY(3),
    .SHOTS(4), .COLOR(12'hfff)
  ) u_gv (
    .clk(clk), .rst(rst), .hcount_in(g_v), .vcount_in(g_h), .rgb_in(g_rgb),
    .play_selected(g_play), .selected(g_sel), .done_in(g_din),
    .rgb_out(gv_rgb), .obstacle_x(gv_x), .obstacle_y(gv_y), .done(gv_done)
  );

  typedef struct {
    logic [11:0] h;
    logic [11:0] v;
    logic [11:0] rgb;
    logic [11:0] exp_rgb;
    logic [11:0] exp_x;
    logic [11:0] exp_y;
  } vec_t;

  vec_t tbl[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_main(input string nm, input bit wa, input bit wp,
                          input logic [11:0] h, input logic [11:0] v,
                          input logic [11:0] r);
    chk({nm, "_asc_rgb"}, int'(a_rgb), wa ? 32'hfff : int'(r));
    chk({nm, "_asc_x"},   int'(a_x),   wa ? int'(h) : 0);
    chk({nm, "_asc_y"},   int'(a_y),   wa ? int'(v) : 0);
    chk({nm, "_pp_rgb"},  int'(p_rgb), wp ? 32'hfff : int'(r));
    chk({nm, "_pp_x"},    int'(p_x),   wp ? int'(h) : 0);
    chk({nm, "_pp_y"},    int'(p_y),   wp ? int'(v) : 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_asc_rgb"}, int'(a_rgb), 0);
    chk({nm, "_asc_xy"},  int'({a_x, a_y}), 0);
    chk({nm, "_asc_done"}, int'(a_done), 0);
    chk({nm, "_pp_rgb"},  int'(p_rgb), 0);
    chk({nm, "_pp_xy"},   int'({p_x, p_y}), 0);
    chk({nm, "_pp_done"}, int'(p_done), 0);
  endtask

  // per-phase probe pattern within one 11-cycle shot, relative to the asc centre
  int ph_h[11]  = '{400, 400, 400, 360, 400, 400, 400, 400, 400, 400, 400};
  int ph_dv[11] = '{0, 1, 2, 0, 2, -1, -1, 2, -2, 3, 4};
  int ph_hw[11] = '{0, 0, 0, 0, 0, 0, 1, 1, 2, 2, 2};
  int cen_a[4]  = '{367, 467, 567, 367};
  int cen_p[4]  = '{367, 467, 567, 467};

  initial begin
    tbl[0] = '{12'd400, 12'd367, 12'h0a5, 12'hfff, 12'd400, 12'd367};
    tbl[1] = '{12'd400, 12'd368, 12'h0b6, 12'hfff, 12'd400, 12'd368};
    tbl[2] = '{12'd400, 12'd369, 12'h0c7, 12'h0c7, 12'd0,   12'd0};
    tbl[3] = '{12'd400, 12'd366, 12'h0d8, 12'h0d8, 12'd0,   12'd0};
    tbl[4] = '{12'd360, 12'd367, 12'h0e9, 12'h0e9, 12'd0,   12'd0};
    tbl[5] = '{12'd361, 12'd367, 12'h1fa, 12'hfff, 12'd361, 12'd367};
    tbl[6] = '{12'd661, 12'd368, 12'h20b, 12'hfff, 12'd661, 12'd368};
    tbl[7] = '{12'd662, 12'd368, 12'h31c, 12'h31c, 12'd0,   12'd0};
    tbl[8] = '{12'd500, 12'd467, 12'h42d, 12'h42d, 12'd0,   12'd0};
    tbl[9] = '{12'd0,   12'd0,   12'h53e, 12'h53e, 12'd0,   12'd0};

    hc = 12'd400; vc = 12'd367; rgb = 12'h5a5;
    play = 1'b1; dinp = 1'b0; sel = 3'b010;
    g_h = 12'd400; g_v = 12'd367; g_rgb = 12'h5a5;
    g_play = 1'b1; g_din = 1'b0; g_sel = 3'b010;

    // reset state
    rst = 1'b1;
    tick(); tick();
    chk_zero("reset");
    chk("reset_gh_rgb", int'(gh_rgb), 0);
    chk("reset_gv_rgb", int'(gv_rgb), 0);
    rst = 1'b0;

    // geometry: idle passthrough, then table in a long SPAWN at hw = 0
    g_rgb = 12'h0ab;
    tick();
    chk("geo_idle_rgb", int'(gh_rgb), 32'h0ab);
    chk("geo_idle_x", int'(gh_x), 0);
    g_din = 1'b1;
    tick();
    g_din = 1'b0;
    for (int i = 0; i < 10; i++) begin
      g_h = tbl[i].h; g_v = tbl[i].v; g_rgb = tbl[i].rgb;
      tick();
      chk($sformatf("geo_h%0d_rgb", i), int'(gh_rgb), int'(tbl[i].exp_rgb));
      chk($sformatf("geo_h%0d_x", i),   int'(gh_x),   int'(tbl[i].exp_x));
      chk($sformatf("geo_h%0d_y", i),   int'(gh_y),   int'(tbl[i].exp_y));
      chk($sformatf("geo_v%0d_rgb", i), int'(gv_rgb), int'(tbl[i].exp_rgb));
      chk($sformatf("geo_v%0d_x", i),   int'(gv_x),   int'(tbl[i].exp_y));
      chk($sformatf("geo_v%0d_y", i),   int'(gv_y),   int'(tbl[i].exp_x));
    end
    g_play = 1'b0;
    tick();
    g_play = 1'b1;

    // wrong code with done_in held: stays idle, one-cycle passthrough
    sel = 3'b001; dinp = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rgb = 12'(k * 100 + 7);
      tick();
      chk($sformatf("wrongsel%0d", k), 0, 0 | int'(a_done) | int'(p_done));
      chk_main($sformatf("wrongsel%0d", k), 1'b0, 1'b0, hc, vc, rgb);
    end

    // full run; done_in kept high well into the run to show it is ignored
    sel = 3'b010; dinp = 1'b1; rgb = 12'h111;
    tick();
    for (int n = 0; n < 47; n++) begin
      int shot, ph, ca, cp, hwv, h, v;
      bit act, wa, wp;
      act = (n < 44);
      if (n >= 21) dinp = 1'b0;
      if (act) begin
        shot = n / 11; ph = n % 11;
        ca = cen_a[shot]; cp = cen_p[shot];
        hwv = ph_hw[ph];
        h = ph_h[ph]; v = ca + ph_dv[ph];
      end else begin
        ca = 0; cp = 0; hwv = 0; h = 400; v = 367;
      end
      hc = 12'(h); vc = 12'(v); rgb = 12'(n * 37 + 5);
      tick();
      wa = act && (h >= 361) && (h <= 661) && (v >= ca - hwv) && (v <= ca + 1 + hwv);
      wp = act && (h >= 361) && (h <= 661) && (v >= cp - hwv) && (v <= cp + 1 + hwv);
      chk_main($sformatf("run%0d", n), wa, wp, hc, vc, rgb);
      chk($sformatf("run%0d_asc_done", n), int'(a_done), (n == 43) ? 1 : 0);
      chk($sformatf("run%0d_pp_done", n),  int'(p_done), (n == 43) ? 1 : 0);
    end

    // abort during GROW
    hc = 12'd400; vc = 12'd367; dinp = 1'b1; rgb = 12'h222;
    tick();
    dinp = 1'b0;
    for (int n = 0; n < 5; n++) begin
      rgb = 12'(n + 12'h230);
      tick();
    end
    play = 1'b0; rgb = 12'h333;
    tick();
    chk_main("abort_edge", 1'b1, 1'b1, hc, vc, rgb);
    play = 1'b1;
    for (int n = 0; n < 45; n++) begin
      rgb = 12'(n * 11 + 1);
      tick();
      chk_main($sformatf("abort%0d", n), 1'b0, 1'b0, hc, vc, rgb);
      chk($sformatf("abort%0d_done", n), int'(a_done) + int'(p_done), 0);
    end

    // reset in HOLD of shot 1, then replay from laser 0 at hw 0
    dinp = 1'b1; rgb = 12'h2a2;
    tick();
    dinp = 1'b0;
    for (int n = 0; n < 20; n++) begin
      rgb = 12'(n + 12'h240);
      tick();
    end
    rst = 1'b1; rgb = 12'h444; vc = 12'd467;
    tick();
    chk_zero("midhold_rst");
    rst = 1'b0; vc = 12'd367; rgb = 12'h555;
    tick();
    chk_main("post_rst_idle", 1'b0, 1'b0, hc, vc, rgb);
    dinp = 1'b1; rgb = 12'h565;
    tick();
    dinp = 1'b0;
    vc = 12'd367; rgb = 12'h666;
    tick();
    chk_main("replay_c367", 1'b1, 1'b1, hc, vc, rgb);
    vc = 12'd467; rgb = 12'h677;
    tick();
    chk_main("replay_c467", 1'b0, 1'b0, hc, vc, rgb);
    vc = 12'd369; rgb = 12'h688;
    tick();
    chk_main("replay_hw0", 1'b0, 1'b0, hc, vc, rgb);
    play = 1'b0;
    tick();
    play = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
